// File: rtl/divider.sv
// divider: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Radix-2 restoring iteration on operand magnitudes with sign fix-up afterwards.
// Divide-by-zero and signed overflow skip the iteration and complete in one step.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_valid  request valid, accepted when i_valid && o_ready && !i_kill
//   o_ready  unit idle and able to accept
//   i_op     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_A      dividend
//   i_B      divisor
//   i_kill   abort the in-flight operation
//   o_valid  one-cycle result pulse
//   o_out    result, held until the next completion
module divider (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_kill,
  output logic        o_valid,
  output logic [31:0] o_out
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] out_q, out_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic        b_zero, ovf;
  logic [32:0] trial;
  logic        trial_ge;
  logic [31:0] trial_diff;

  assign signed_op = ~i_op[0];
  assign a_mag     = (signed_op && i_A[31]) ? (32'd0 - i_A) : i_A;
  assign b_mag     = (signed_op && i_B[31]) ? (32'd0 - i_B) : i_B;
  assign b_zero    = (i_B == 32'd0);
  assign ovf       = signed_op && (i_A == 32'h8000_0000) && (i_B == 32'hFFFF_FFFF);

  // 33-bit trial: the shifted remainder can exceed 32 bits when the divisor is large.
  assign trial      = {rem_q, dvd_q[31]};
  assign trial_ge   = (trial >= {1'b0, dvs_q});
  // Only used when trial >= divisor, so the true difference is below 2^32.
  assign trial_diff = trial[31:0] - dvs_q;

  assign o_ready = (state_q == StIdle) && !i_rst;
  assign o_valid = valid_q;
  assign o_out   = out_q;

  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    out_d     = out_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid && !i_kill) begin
          if (b_zero) begin
            out_d   = i_op[1] ? i_A : 32'hFFFF_FFFF;
            state_d = StDone;
          end else if (ovf) begin
            out_d   = i_op[1] ? 32'd0 : 32'h8000_0000;
            state_d = StDone;
          end else begin
            is_rem_d  = i_op[1];
            neg_quo_d = signed_op & (i_A[31] ^ i_B[31]);
            neg_rem_d = signed_op & i_A[31];
            dvd_d     = a_mag;
            dvs_d     = b_mag;
            rem_d     = 32'd0;
            cnt_d     = 5'd0;
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        if (i_kill) begin
          state_d = StIdle;
        end else begin
          // Quotient bits shift into dvd as the dividend bits shift out.
          rem_d = trial_ge ? trial_diff : trial[31:0];
          dvd_d = {dvd_q[30:0], trial_ge};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (i_kill) begin
          state_d = StIdle;
        end else begin
          if (is_rem_q) begin
            out_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
          end else begin
            out_d = neg_quo_q ? (32'd0 - dvd_q) : dvd_q;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        // First DONE cycle raises the registered pulse; the second retires it.
        valid_d = ~valid_q;
        if (valid_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      cnt_q     <= 5'd0;
      valid_q   <= 1'b0;
      out_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      out_q     <= out_d;
    end
  end

endmodule
